// File: rtl/led_matrix_scan.sv
// Row-scan driver for an 8x8 LED matrix: merges three (Sx, Sy) sources into a
// per-frame snapshot and drives it one row at a time, with blanking before each row.
module led_matrix_scan #(
    parameter int DWELL = 1000,
    parameter int BLANK = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [7:0] Sx_p1,
    input  logic [7:0] Sy_p1,
    input  logic [7:0] Sx_p2,
    input  logic [7:0] Sy_p2,
    input  logic [7:0] Sx_b,
    input  logic [7:0] Sy_b,
    output logic [7:0] row_n,
    output logic [7:0] col,
    output logic [2:0] row_idx,
    output logic       frame_start
);

    localparam logic [15:0] BLANK_LAST = 16'(BLANK - 1);
    localparam logic [15:0] DWELL_LAST = 16'(DWELL - 1);

    // Two park flavours: after reset the cleared buffer is shown first;
    // after en drops the buffer reloads from live inputs on unpark.
    typedef enum logic [1:0] {
        ST_RST_PARK,
        ST_PARK,
        ST_BLANK,
        ST_DRIVE
    } state_t;

    state_t      state, nxt_state;
    logic [2:0]  row, nxt_row;
    logic [15:0] cnt, nxt_cnt;
    logic        load, start;
    logic [7:0]  frame    [8];
    logic [7:0]  frame_in [8];

    always_comb begin
        for (int r = 0; r < 8; r++) begin
            frame_in[r] = (Sx_p1 & {8{~Sy_p1[r]}})
                        | (Sx_p2 & {8{~Sy_p2[r]}})
                        | (Sx_b  & {8{~Sy_b[r]}});
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_RST_PARK;
            row   <= 3'd0;
            cnt   <= 16'd0;
        end else begin
            state <= nxt_state;
            row   <= nxt_row;
            cnt   <= nxt_cnt;
        end
    end

    always_comb begin
        nxt_state = state;
        nxt_row   = row;
        nxt_cnt   = cnt;
        load      = 1'b0;
        start     = 1'b0;
        if (!en) begin
            nxt_state = (state == ST_RST_PARK) ? ST_RST_PARK : ST_PARK;
            nxt_row   = 3'd0;
            nxt_cnt   = 16'd0;
        end else begin
            case (state)
                ST_RST_PARK: begin
                    nxt_state = ST_BLANK;
                    nxt_row   = 3'd0;
                    nxt_cnt   = 16'd0;
                    start     = 1'b1;
                end
                ST_PARK: begin
                    nxt_state = ST_BLANK;
                    nxt_row   = 3'd0;
                    nxt_cnt   = 16'd0;
                    load      = 1'b1;
                    start     = 1'b1;
                end
                ST_BLANK: begin
                    if (cnt == BLANK_LAST) begin
                        nxt_state = ST_DRIVE;
                        nxt_cnt   = 16'd0;
                    end else begin
                        nxt_cnt = cnt + 16'd1;
                    end
                end
                ST_DRIVE: begin
                    if (cnt == DWELL_LAST) begin
                        nxt_state = ST_BLANK;
                        nxt_cnt   = 16'd0;
                        nxt_row   = row + 3'd1;
                        if (row == 3'd7) begin
                            load  = 1'b1;
                            start = 1'b1;
                        end
                    end else begin
                        nxt_cnt = cnt + 16'd1;
                    end
                end
                default: begin
                    nxt_state = ST_PARK;
                    nxt_row   = 3'd0;
                    nxt_cnt   = 16'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < 8; r++) frame[r] <= 8'h00;
        end else if (load) begin
            for (int r = 0; r < 8; r++) frame[r] <= frame_in[r];
        end
    end

    // Outputs are registered from the next state so they match the state flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_n       <= 8'hFF;
            col         <= 8'h00;
            row_idx     <= 3'd0;
            frame_start <= 1'b0;
        end else begin
            row_idx     <= nxt_row;
            frame_start <= start;
            if (nxt_state == ST_DRIVE) begin
                row_n <= ~(8'h01 << nxt_row);
                col   <= frame[nxt_row];
            end else begin
                row_n <= 8'hFF;
                col   <= 8'h00;
            end
        end
    end

endmodule

// File: tb/tb_led_matrix_scan.sv
// Randomized scoreboard bench for led_matrix_scan; a frame-time reference model
// predicts {row_n, col, row_idx, frame_start} for every cycle.
module tb_led_matrix_scan;

    localparam int DW    = 4;
    localparam int BL    = 2;
    localparam int ROWP  = BL + DW;
    localparam int FRAME = 8 * ROWP;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic [7:0] Sx_p1 = 8'h00, Sy_p1 = 8'hFF;
    logic [7:0] Sx_p2 = 8'h00, Sy_p2 = 8'hFF;
    logic [7:0] Sx_b  = 8'h00, Sy_b  = 8'hFF;
    logic [7:0] row_n, col;
    logic [2:0] row_idx;
    logic       frame_start;

    int tests  = 0;
    int failed = 0;

    logic [19:0] exp_q[$];

    led_matrix_scan #(.DWELL(DW), .BLANK(BL)) dut (
        .clk(clk), .rst_n(rst_n), .en(en),
        .Sx_p1(Sx_p1), .Sy_p1(Sy_p1), .Sx_p2(Sx_p2), .Sy_p2(Sy_p2),
        .Sx_b(Sx_b), .Sy_b(Sy_b),
        .row_n(row_n), .col(col), .row_idx(row_idx), .frame_start(frame_start)
    );

    // clock / reset
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // mode 0 = parked after reset, 1 = parked by en, 2 = scanning
    int         m_mode = 0;
    int         m_t = 0;
    logic [7:0] m_frame [8];

    task automatic snapshot();
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 8; c++) begin
                m_frame[r][c] = (Sx_p1[c] & ~Sy_p1[r]) | (Sx_p2[c] & ~Sy_p2[r])
                              | (Sx_b[c] & ~Sy_b[r]);
            end
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        logic [7:0] e_row_n, e_col;
        logic [2:0] e_idx;
        logic       e_fs;
        if (!rst_n) begin
            m_mode = 0;
            m_t    = 0;
            for (int r = 0; r < 8; r++) m_frame[r] = 8'h00;
            exp_q.delete();
        end else begin
            e_fs = 1'b0;
            if (!en) begin
                if (m_mode != 0) m_mode = 1;
                m_t = 0;
            end else if (m_mode == 0) begin
                m_mode = 2; m_t = 0; e_fs = 1'b1;
            end else if (m_mode == 1) begin
                snapshot();
                m_mode = 2; m_t = 0; e_fs = 1'b1;
            end else begin
                m_t = m_t + 1;
                if (m_t == FRAME) begin
                    m_t = 0; snapshot(); e_fs = 1'b1;
                end
            end
            e_row_n = 8'hFF;
            e_col   = 8'h00;
            e_idx   = 3'd0;
            if (m_mode == 2) begin
                e_idx = 3'(m_t / ROWP);
                if ((m_t % ROWP) >= BL) begin
                    e_row_n = 8'hFF;
                    e_row_n[m_t / ROWP] = 1'b0;
                    e_col = m_frame[m_t / ROWP];
                end
            end
            exp_q.push_back({e_row_n, e_col, e_idx, e_fs});
        end
    end

    // ---------------- monitor ----------------
    always @(posedge clk) begin
        logic [19:0] got, expv;
        #1;
        got = {row_n, col, row_idx, frame_start};
        if (!rst_n) begin
            tests++;
            if (got !== {8'hFF, 8'h00, 3'd0, 1'b0}) begin
                failed++;
                $display("FAIL reset_hold got=%h required=%h", got, {8'hFF, 8'h00, 3'd0, 1'b0});
            end
        end else begin
            tests++;
            if (exp_q.size() == 0) begin
                failed++;
                $display("FAIL scoreboard_empty at %0t", $time);
            end else begin
                expv = exp_q.pop_front();
                if (got !== expv) begin
                    failed++;
                    $display("FAIL scan_out t=%0t got row_n=%h col=%h idx=%0d fs=%b required row_n=%h col=%h idx=%0d fs=%b",
                             $time, got[19:12], got[11:4], got[3:1], got[0],
                             expv[19:12], expv[11:4], expv[3:1], expv[0]);
                end
            end
            tests++;
            if ($countones(~row_n) > 1 || (row_n == 8'hFF && col != 8'h00)) begin
                failed++;
                $display("FAIL row_invariant got row_n=%h col=%h required one-hot-low or blank", row_n, col);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic set_src(input logic [7:0] x1, y1, x2, y2, xb, yb);
        Sx_p1 = x1; Sy_p1 = y1; Sx_p2 = x2; Sy_p2 = y2; Sx_b = xb; Sy_b = yb;
    endtask

    task automatic rand_src();
        set_src(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
                8'($urandom), 8'($urandom));
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_fs();
        bit seen = 0;
        for (int i = 0; i < 3 * FRAME && !seen; i++) begin
            @(posedge clk); #1;
            if (frame_start) seen = 1;
        end
        tests++;
        if (!seen) begin
            failed++;
            $display("FAIL wait_frame_start got none required pulse within %0d cycles", 3 * FRAME);
        end
    endtask

    task automatic check_async_reset();
        rst_n = 1'b0;
        #1;
        tests++;
        if ({row_n, col, row_idx, frame_start} !== {8'hFF, 8'h00, 3'd0, 1'b0}) begin
            failed++;
            $display("FAIL async_reset got row_n=%h col=%h idx=%0d fs=%b required FF 00 0 0",
                     row_n, col, row_idx, frame_start);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        // reset with toggling inputs, then release with en high and nonzero inputs
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); rand_src(); en = 1'($urandom);
        end
        @(negedge clk);
        set_src(8'hFF, 8'h00, 8'h00, 8'hFF, 8'h00, 8'hFF);
        en = 1'b1;
        rst_n = 1'b1;
        cycles(2 * FRAME);

        // paddle 2 at position 3
        set_src(8'h00, 8'hFF, 8'h38, 8'hFE, 8'h00, 8'hFF);
        cycles(2 * FRAME);

        // overlap of paddle 1 and ball on row 7, then ball alone on row 4
        set_src(8'h07, 8'h7F, 8'h00, 8'hFF, 8'h04, 8'h7F);
        cycles(2 * FRAME);
        set_src(8'h00, 8'hFF, 8'h00, 8'hFF, 8'h10, 8'hEF);
        cycles(2 * FRAME);

        // mid-frame change during row 2 drive
        set_src(8'h00, 8'hFF, 8'h38, 8'hFE, 8'h00, 8'hFF);
        wait_fs();
        wait_fs();
        cycles(2 * ROWP + BL + 1);
        Sx_p2 = 8'h0E;
        cycles(2 * FRAME);

        // en dropped during row 4 drive, inputs changed while parked
        wait_fs();
        cycles(4 * ROWP + BL + 1);
        en = 1'b0;
        cycles(3);
        rand_src();
        cycles(3);
        en = 1'b1;
        cycles(2 * FRAME);

        // reset pulse mid row 6 drive
        wait_fs();
        repeat (6 * ROWP + BL + 1) @(posedge clk);
        #3;
        check_async_reset();
        cycles(2);
        rand_src();
        rst_n = 1'b1;
        cycles(2 * FRAME);

        // random segments with en toggling
        for (int s = 0; s < 20; s++) begin
            rand_src();
            if ($urandom_range(0, 3) == 0) en = ~en;
            else en = 1'b1;
            cycles($urandom_range(1, 70));
        end
        en = 1'b1;
        cycles(FRAME);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/led_matrix_scan.md
# led_matrix_scan

Row-scan driver for the 8x8 LED matrix. It consumes the (Sx, Sy) pixel patterns from the two paddle writers and the ball writer, and merges them into a snapshot frame buffer. It then time-multiplexes that frame onto the physical matrix one row at a time, with blanking between rows to suppress ghosting. It sits between the game-object writers and the matrix pins.

## Interface
- DWELL, 1000: cycles each row is driven (1..65535).
- BLANK, 16: all-off cycles before each row (1..65535).

- clk  input  1  system clock, all state on rising edge
- rst_n  input  1  asynchronous, active-low reset
- en  input  1  scan enable; 0 blanks the matrix and parks the scan
- Sx_p1, Sy_p1  input  8 each  paddle 1 pattern (Sx column bits active-high, Sy row bits active-low)
- Sx_p2, Sy_p2  input  8 each  paddle 2 pattern
- Sx_b, Sy_b  input  8 each  ball pattern
- row_n  output  8  matrix row drive, active-low, at most one bit low
- col  output  8  matrix column drive, active-high
- row_idx  output  3  row currently in scan
- frame_start  output  1  one-cycle pulse at start of each frame

## Operation
- Pixel decode per source: pix[r][c] = Sx[c] & ~Sy[r]. Frame = OR of the three sources. A source with Sx=0 contributes nothing, whatever its Sy.
- The frame buffer is 8 registers of 8 bits, frame[r][c]. It loads only on the edge that enters state (row 0, BLANK, cnt 0) from the end of row 7 DRIVE or from park. Input changes at any other time are not displayed until the next frame.
- State: row r (0..7), phase {BLANK, DRIVE}, counter cnt (16 bits).
  - BLANK: cnt counts 0..BLANK-1, then goes to DRIVE with cnt=0.
  - DRIVE: cnt counts 0..DWELL-1, then goes to BLANK of row r+1 with cnt=0.
  - Row 7 DRIVE end wraps to row 0 BLANK and reloads the buffer.
- Outputs are driven from flops and reflect the current state:
  - BLANK: row_n=8'hFF, col=8'h00.
  - DRIVE: row_n=~(8'h01<<r), col=frame[r].
  - row_idx=r at all times.
- en=0 sampled at an edge forces the state to park (row 0, BLANK, cnt 0, held) with outputs blank and frame_start=0. The first edge with en=1 reloads the buffer from the current inputs, asserts frame_start, and starts counting from row 0 BLANK cnt 0.
- Reset state is park. The buffer is cleared, so a frame with en held high from reset displays all-off on the first frame.

## Timing
- Reset values: row_n=8'hFF, col=8'h00, row_idx=0, frame_start=0, buffer=0, state=park.
- Row period = BLANK+DWELL cycles. Frame period = 8*(BLANK+DWELL) cycles.
- frame_start is high for exactly the cycle in state (row 0, BLANK, cnt 0) following a wrap or an unpark. It is low otherwise, including while parked.
- Latency from buffer load to first lit row-0 pixel is BLANK cycles.
- row_n is never low during BLANK. No two bits of row_n are ever low simultaneously.
- en falling mid-row: outputs go blank on the next edge and the scan restarts from row 0 when en returns. There is no partial-row resume.
- rst_n asserted mid-frame: outputs take reset values immediately (asynchronous), independent of clk.

## Test plan
(Bench uses DWELL=4, BLANK=2, so the frame is 48 cycles.)
- Reset: rst_n low with inputs toggling -> row_n=FF, col=00, frame_start=0. Release with en=1 -> the first frame is all-off, frame_start pulses at cycles 0 and 48, and row_n walks FE, FD, …, 7F across 4-cycle windows separated by 2 blank cycles.
- Paddle 2 at pos 3: Sx_p2=8'h38, Sy_p2=8'hFE, other sources 0 -> in the second frame, col=38 only while row_n=FE, and col=00 in all other rows and all blanks.
- Overlap: paddle 1 Sx=8'h07, Sy=8'h7F plus ball Sx=8'h04, Sy=8'h7F -> col=07 on row_n=7F. Ball at Sx=8'h10, Sy=8'hEF -> col=10 on row_n=EF.
- Mid-frame change: alter Sx_p2 from 38 to 0E during row 2 DRIVE -> row 0 keeps showing 38 for the rest of this frame and shows 0E only after the next frame_start.
- en dropped during row 4 DRIVE -> blank on the next edge, frame_start stays low, row_idx=0. Raising en -> a frame_start pulse, the buffer is reloaded from the current inputs, and row 0 is lit 2 cycles later.
- rst_n pulsed low mid-row 6 -> immediate row_n=FF, col=00, buffer cleared. After release, the scan restarts at row 0 and the first frame is blank.
